// File: rtl/accum_ctrl.sv
// accum_ctrl: request sequencer for the word-count accumulator array.
//
// In ACCUM it turns a valid/ready stream of hits into accumulator writes and
// stalls one cycle when a hit would read a stale entry from the
// read-modify-write pipeline. On drain_start it waits for in-flight writes to
// land (FLUSH). It then streams every entry out through the result port (DRAIN)
// and returns to ACCUM.
//
// Optional feature (macro ACCUM_CTRL_SKIP_ZERO_EN): in DRAIN, entries whose
// count field acc_q[31:0] is zero are skipped rather than presented.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   in_valid/in_ready         hit handshake; in_addr, in_inc, in_tag carry the hit
//   drain_start               one-cycle request to dump the array
//   drain_busy, drain_done    drain status / completion pulse
//   acc_addr, acc_din, acc_we request port to the accumulator
//   acc_q                     accumulator read data, one cycle after acc_addr
//   out_valid/out_ready       result handshake; out_addr, out_data carry the entry
module accum_ctrl #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [31:0]           in_inc,
  input  logic [31:0]           in_tag,
  input  logic                  drain_start,
  output logic                  drain_busy,
  output logic                  drain_done,
  output logic [31:0]           acc_addr,
  output logic [63:0]           acc_din,
  output logic                  acc_we,
  input  logic [63:0]           acc_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [63:0]           out_data
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = '1;

  typedef enum logic [1:0] {StAccum, StFlush, StDrain} state_e;

  state_e                state_q, state_d;
  logic                  h1_vld_q, h1_vld_d, h2_vld_q, h2_vld_d;
  logic [ADDR_WIDTH-1:0] h1_addr_q, h1_addr_d, h2_addr_q, h2_addr_d;
  logic [1:0]            flush_cnt_q, flush_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  drain_done_q, drain_done_d;

  logic                  hazard;
  logic                  fire;
  logic                  present;
  logic                  ready_int;
  logic                  we_int;
  logic [ADDR_WIDTH-1:0] acc_idx;

  // Entry issued two cycles ago would be read before its write lands, unless
  // the previous cycle hit the same entry (the accumulator bypasses that case).
  assign hazard = h2_vld_q && (h2_addr_q == in_addr) && !(h1_vld_q && (h1_addr_q == in_addr));

`ifdef ACCUM_CTRL_SKIP_ZERO_EN
  // Zero-count entries advance the pointer without a handshake.
  assign present = out_valid_q && (acc_q[31:0] != 32'd0);
  assign fire    = out_valid_q && (out_ready || (acc_q[31:0] == 32'd0));
`else
  assign present = out_valid_q;
  assign fire    = out_valid_q && out_ready;
`endif

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    out_valid_d  = 1'b0;
    drain_done_d = 1'b0;
    ready_int    = 1'b0;
    we_int       = 1'b0;
    acc_idx      = '0;

    unique case (state_q)
      StAccum: begin
        ready_int = !hazard;
        we_int    = in_valid && !hazard;
        acc_idx   = in_addr;
        if (drain_start) begin
          state_d     = StFlush;
          flush_cnt_d = 2'd0;
        end
      end
      StFlush: begin
        flush_cnt_d = flush_cnt_q + 2'd1;
        if (flush_cnt_q == 2'd2) begin
          state_d  = StDrain;
          rd_ptr_d = '0;
        end
      end
      StDrain: begin
        // Look one entry ahead on fire so the next word arrives without a bubble.
        acc_idx     = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, fire};
        out_valid_d = 1'b1;
        if (fire) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == LastIdx) begin
            out_valid_d  = 1'b0;
            drain_done_d = 1'b1;
            state_d      = StAccum;
            rd_ptr_d     = '0;
          end
        end
      end
      default: state_d = StAccum;
    endcase

    // History shifts every cycle; only ACCUM can set an issue flag.
    h1_vld_d  = we_int;
    h1_addr_d = in_addr;
    h2_vld_d  = h1_vld_q;
    h2_addr_d = h1_addr_q;
    if (drain_done_d) begin
      h1_vld_d  = 1'b0;
      h1_addr_d = '0;
      h2_vld_d  = 1'b0;
      h2_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StAccum;
      h1_vld_q     <= 1'b0;
      h1_addr_q    <= '0;
      h2_vld_q     <= 1'b0;
      h2_addr_q    <= '0;
      flush_cnt_q  <= 2'd0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h1_vld_q     <= h1_vld_d;
      h1_addr_q    <= h1_addr_d;
      h2_vld_q     <= h2_vld_d;
      h2_addr_q    <= h2_addr_d;
      flush_cnt_q  <= flush_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      drain_done_q <= drain_done_d;
    end
  end

  // Outputs are gated by reset_n so an assertion of reset takes effect at once.
  assign in_ready   = reset_n && ready_int;
  assign acc_we     = reset_n && we_int;
  assign acc_addr   = reset_n ? 32'(acc_idx) : 32'd0;
  assign acc_din    = {in_tag, in_inc};
  assign out_valid  = reset_n && present;
  assign out_addr   = rd_ptr_q;
  assign out_data   = acc_q;
  assign drain_done = reset_n && drain_done_q;
  assign drain_busy = reset_n && ((state_q != StAccum) || drain_done_q);

endmodule
